// File: rtl/prbs_checker.sv
// PRBS checker for the 32-bit Fibonacci LFSR with taps 32/30/26/25.
// Locks after LOCK_CNT good predictions, then flywheels on its own predictions.
module prbs_checker #(
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned LOSS_WINDOW = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinW   = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int unsigned WerrW  = $clog2(LOSS_THRESH + 1);

  localparam logic [MatchW-1:0] LockCntV = MatchW'(LOCK_CNT);
  localparam logic [WinW-1:0]   WinLastV = WinW'(LOSS_WINDOW - 1);
  localparam logic [WerrW-1:0]  ThreshV  = WerrW'(LOSS_THRESH);

  typedef enum logic {StSearch, StLocked} state_e;

  state_e            state_q, state_d;
  logic [31:0]       h_q, h_d;
  logic [5:0]        fill_q, fill_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [WerrW-1:0]  werr_q, werr_d;
  logic [WerrW-1:0]  werr_inc;
  logic [15:0]       err_count_q, err_count_d;
  logic              err_pulse_q, err_pulse_d;
  logic              pred, mismatch;

  assign pred     = h_q[31] ^ h_q[29] ^ h_q[25] ^ h_q[24];
  assign mismatch = pred ^ in_bit;
  assign werr_inc = werr_q + WerrW'(1);

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StSearch: begin
          h_d = {h_q[30:0], in_bit};
          if (fill_q != 6'd32) fill_d = fill_q + 6'd1;
          // An all-zero history predicts zeros forever; never let it count as sync.
          if (h_q == 32'd0) begin
            match_d = '0;
          end else if (fill_q == 6'd32) begin
            if (mismatch) begin
              match_d = '0;
            end else begin
              match_d = match_q + MatchW'(1);
              if (match_d == LockCntV) begin
                state_d = StLocked;
                win_d   = '0;
                werr_d  = '0;
              end
            end
          end
        end
        StLocked: begin
          // Flywheel on the prediction so line errors never corrupt the history.
          h_d = {h_q[30:0], pred};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end
          if (mismatch && (werr_inc == ThreshV)) begin
            state_d = StSearch;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WinLastV) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + WinW'(1);
            if (mismatch) werr_d = werr_inc;
          end
        end
        default: ;
      endcase
    end
    if (clr_cnt) err_count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSearch;
      h_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 64: consecutive correct predictions required to declare lock.
REQ-002 SHALL have parameter LOSS_THRESH, default 8: mismatches within one window that drop lock.
REQ-003 SHALL have parameter LOSS_WINDOW, default 256: window length in valid bits while locked.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, qualifies in_bit; no state advances when low.
REQ-007 SHALL have port in_bit, input, 1, received serial PRBS bit.
REQ-008 SHALL have port clr_cnt, input, 1, synchronous clear of err_count.
REQ-009 SHALL have port locked, output, 1, checker is synchronised to the sequence.
REQ-010 SHALL have port err_pulse, output, 1, one-cycle flag for a mismatched bit while locked.
REQ-011 SHALL have port err_count, output, 16, saturating count of locked-mode mismatches.

Function
REQ-012 SHALL check the sequence b[n] = b[n-32] ^ b[n-30] ^ b[n-26] ^ b[n-25]: the team's 32-bit Fibonacci LFSR with taps 32/30/26/25, one new feedback bit per cycle.
REQ-013 SHALL hold a 32-bit history register h, where h[k] = the bit (k+1) valid bits ago; prediction p = h[31]^h[29]^h[25]^h[24].
REQ-014 SHALL implement two states, SEARCH and LOCKED, with 6-bit fill counter (0..32), match counter, window counter and window error counter.
REQ-015 SEARCH, per valid bit: shift in_bit into h[0]; increment fill until it saturates at 32; compare p with in_bit only when fill==32.
REQ-016 SEARCH: a match increments match counter; a mismatch clears it; match counter also clears while h is all zeros (a stuck-at-0 input never locks).
REQ-017 SEARCH -> LOCKED when a match brings match counter to LOCK_CNT; locked SHALL rise on the following edge, i.e. registered, one cycle after the qualifying bit is sampled.
REQ-018 LOCKED, per valid bit: shift p (not in_bit) into h[0], so received errors never propagate into predictions.
REQ-019 LOCKED: on p != in_bit, err_pulse SHALL be 1 for exactly the next cycle; err_count increments, saturating at 0xFFFF; window error counter increments.
REQ-020 LOCKED: window counter counts valid bits 0..LOSS_WINDOW-1 and wraps.
- On wrap, window error counter clears.
- A mismatch on the last bit of a window counts toward that window's threshold check before the clear.
REQ-021 LOCKED -> SEARCH when window error counter reaches LOSS_THRESH; locked falls on the next edge; fill, match, window and window error counters clear; h is retained but refilled.
REQ-022 SEARCH SHALL never assert err_pulse nor change err_count.
REQ-023 in_valid low SHALL freeze all state; err_pulse is 0 in any cycle after an edge where in_valid was low.
REQ-024 clr_cnt high SHALL set err_count to 0 on that edge; clear overrides a simultaneous increment; err_pulse is unaffected.
REQ-025 Entry into LOCKED SHALL start window counter and window error counter at 0; err_count persists across lock changes.

Reset
REQ-026 rst_n low SHALL immediately force SEARCH, h=0, all counters 0, locked=0, err_pulse=0, err_count=0, regardless of clk.
REQ-027 First valid bit after rst_n deassertion SHALL be treated as fill bit 1.

Verification
REQ-028 Reset, stream from generator seeded 32'h1, in_valid=1 -> locked=1 one cycle after bit 96 (32 fill + 64 matches); err_count=0 thereafter.
REQ-029 Locked, invert one bit -> err_pulse high one cycle, err_count=1, locked stays 1; next 500 bits produce no further pulses.
REQ-030 in_bit=0 constant for 2000 bits after reset -> locked stays 0, err_count=0.
REQ-031 Locked, invert 8 bits within one 256-bit window -> locked falls one cycle after the 8th error, err_count=8; clean stream then relocks 96 valid bits later.
REQ-032 Invert 7 bits at window end plus 7 in the next window -> lock retained, err_count=14.
REQ-033 Repeat REQ-028 with random in_valid gaps; also assert rst_n mid-lock -> identical bit-count results; outputs zero asynchronously on reset.
